imem_loader: RTL and testbench

//  Write-side companion to the InstructionMemory read port. Accepts a byte stream

---
 rtl/imem_loader.sv | 130 +++++++++++++
 tb/tb_imem_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Write-side companion to the instruction memory read port. Takes a byte
//   stream over a valid/ready handshake, assembles big-endian 32-bit MIPS
//   instructions and writes each one to consecutive word addresses. The CPU
//   is held stalled until the requested program image has been written.
//
// Parameters
//   DEPTH       instruction memory depth in words; addresses wrap modulo DEPTH
//   START_ADDR  word address of the first instruction written
//
// Ports
//   clk         system clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   start       1-cycle load request, honoured only when idle or done
//   num_words   number of words to load, latched when start is accepted
//   byte_in     stream byte
//   byte_valid  byte_in is valid
//   byte_ready  loader accepts byte_in this cycle
//   mem_we      instruction memory write strobe, one cycle per word
//   mem_addr    word address of the write
//   mem_wdata   instruction word being written
//   cpu_hold    1 = processor stalled
//   done        level, last requested load has completed

module imem_loader #(
    parameter int DEPTH      = 256,
    parameter int START_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] num_words,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [31:0] FIRST_ADDR = 32'(START_ADDR);
    localparam logic [31:0] LAST_ADDR  = 32'(DEPTH - 1);

    logic [1:0]  state;
    logic [31:0] remaining;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_word;
    logic [31:0] word_addr;
    logic        finishing;
    logic        xfer;

    // finishing marks the single cycle in LOAD after the last word has been
    // handed to memory (or right after a zero-length start); no more bytes are
    // taken and the next edge moves to DONE.
    assign byte_ready = (state == S_LOAD) && !finishing;
    assign xfer       = byte_valid && byte_ready;

    // Main sequencer. The first three bytes of a word collect in asm_word;
    // the fourth byte goes straight into mem_wdata together with them, so the
    // assembly register is free again during the write cycle and the stream
    // can keep flowing at one byte per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remaining <= 32'd0;
            byte_cnt  <= 2'd0;
            asm_word  <= 24'd0;
            word_addr <= 32'd0;
            finishing <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        remaining <= num_words;
                        byte_cnt  <= 2'd0;
                        word_addr <= FIRST_ADDR;
                        done      <= 1'b0;
                        cpu_hold  <= 1'b1;
                        state     <= S_LOAD;
                        // A zero-length load passes through one quiet LOAD
                        // cycle so done rises on the second edge.
                        finishing <= (num_words == 32'd0);
                    end
                end
                S_LOAD: begin
                    if (finishing) begin
                        finishing <= 1'b0;
                        done      <= 1'b1;
                        cpu_hold  <= 1'b0;
                        state     <= S_DONE;
                    end else if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: asm_word[23:16] <= byte_in;
                            2'd1: asm_word[15:8]  <= byte_in;
                            2'd2: asm_word[7:0]   <= byte_in;
                            default: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= word_addr;
                                mem_wdata <= {asm_word, byte_in};
                                word_addr <= (word_addr == LAST_ADDR) ? 32'd0
                                                                      : word_addr + 32'd1;
                                remaining <= remaining - 32'd1;
                                if (remaining == 32'd1) begin
                                    finishing <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [31:0] num_words;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        ready0, we0, hold0, done0;
    logic [31:0] addr0, wdata0;
    logic        ready1, we1, hold1, done1;
    logic [31:0] addr1, wdata1;

    int numChecks = 0;
    int numFails  = 0;

    logic [7:0]  stream [0:31];
    logic [31:0] log0Addr [0:31];
    logic [31:0] log0Data [0:31];
    logic [31:0] log1Addr [0:31];
    logic [31:0] log1Data [0:31];
    int          log0N = 0;
    int          log1N = 0;
    int          base0;
    int          base1;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(256), .START_ADDR(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .num_words(num_words),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready0),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .cpu_hold(hold0), .done(done0)
    );

    // Second instance exercises the address wrap from the top of memory.
    imem_loader #(.DEPTH(8), .START_ADDR(7)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .num_words(num_words),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready1),
        .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .cpu_hold(hold1), .done(done1)
    );

    // Record every memory write of both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (we0 && log0N < 32) begin
            log0Addr[log0N] <= addr0;
            log0Data[log0N] <= wdata0;
            log0N           <= log0N + 1;
        end
        if (we1 && log1N < 32) begin
            log1Addr[log1N] <= addr1;
            log1Data[log1N] <= wdata1;
            log1N           <= log1N + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One-cycle start pulse to the selected instance.
    task automatic applyStimulus(input bit unit, input int n);
        @(negedge clk);
        num_words = n;
        if (unit) start1 = 1'b1;
        else      start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Push n bytes from stream[first..], optionally idling every other cycle.
    // Returns at the negedge after the last byte was accepted.
    task automatic sendStream(input int first, input int n, input bit gaps);
        int  i      = 0;
        int  budget = 100;
        bit  toggle = 1'b0;
        logic rdy;
        while (i < n && budget > 0) begin
            @(negedge clk);
            budget--;
            rdy = ready0 | ready1;
            if (gaps && toggle) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_in    = stream[first + i];
                if (rdy) i++;
            end
            toggle = !toggle;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        if (i < n) checkOutput("stream_timeout", 32'(i), 32'(n));
    endtask

    task automatic waitDone(input bit unit);
        int budget = 50;
        while (budget > 0 && !(unit ? done1 : done0)) begin
            @(negedge clk);
            budget--;
        end
        checkOutput(unit ? "done1_seen" : "done0_seen", {31'd0, unit ? done1 : done0}, 32'd1);
    endtask

    initial begin
        stream[0]  = 8'h8C; stream[1]  = 8'h01; stream[2]  = 8'h00; stream[3]  = 8'h04;
        stream[4]  = 8'h00; stream[5]  = 8'h22; stream[6]  = 8'h18; stream[7]  = 8'h20;
        stream[8]  = 8'h11; stream[9]  = 8'h22; stream[10] = 8'h33; stream[11] = 8'h44;
        stream[12] = 8'h55; stream[13] = 8'h66; stream[14] = 8'h77; stream[15] = 8'h88;
        stream[16] = 8'h99; stream[17] = 8'hAA; stream[18] = 8'hBB; stream[19] = 8'hCC;
        stream[20] = 8'h12; stream[21] = 8'h34; stream[22] = 8'h56; stream[23] = 8'h78;
        stream[24] = 8'h01; stream[25] = 8'h02; stream[26] = 8'h03; stream[27] = 8'h04;
        stream[28] = 8'hA0; stream[29] = 8'hB0; stream[30] = 8'hC0; stream[31] = 8'hD0;

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; num_words = 32'd0;
        byte_in = 8'd0; byte_valid = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_hold",  {31'd0, hold0},  32'd1);
        checkOutput("rst_done",  {31'd0, done0},  32'd0);
        checkOutput("rst_ready", {31'd0, ready0}, 32'd0);
        checkOutput("rst_we",    {31'd0, we0},    32'd0);
        checkOutput("rst_addr",  addr0,           32'd0);
        checkOutput("rst_wdata", wdata0,          32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_hold", {31'd0, hold0}, 32'd1);

        $display("[TB] two-word back-to-back load");
        base0 = log0N;
        applyStimulus(1'b0, 2);
        checkOutput("load_ready", {31'd0, ready0}, 32'd1);
        checkOutput("load_hold",  {31'd0, hold0},  32'd1);
        sendStream(0, 8, 1'b0);
        checkOutput("last_ready", {31'd0, ready0}, 32'd0);
        checkOutput("last_we",    {31'd0, we0},    32'd1);
        waitDone(1'b0);
        checkOutput("t2_hold",  {31'd0, hold0}, 32'd0);
        checkOutput("t2_count", 32'(log0N - base0), 32'd2);
        checkOutput("t2_addr0", log0Addr[base0],     32'd0);
        checkOutput("t2_data0", log0Data[base0],     32'h8C010004);
        checkOutput("t2_addr1", log0Addr[base0 + 1], 32'd1);
        checkOutput("t2_data1", log0Data[base0 + 1], 32'h00221820);
        checkOutput("done_ready", {31'd0, ready0}, 32'd0);

        $display("[TB] two-word load with gaps");
        base0 = log0N;
        applyStimulus(1'b0, 2);
        checkOutput("restart_done", {31'd0, done0}, 32'd0);
        checkOutput("restart_hold", {31'd0, hold0}, 32'd1);
        sendStream(0, 8, 1'b1);
        waitDone(1'b0);
        checkOutput("t3_count", 32'(log0N - base0), 32'd2);
        checkOutput("t3_addr0", log0Addr[base0],     32'd0);
        checkOutput("t3_data0", log0Data[base0],     32'h8C010004);
        checkOutput("t3_addr1", log0Addr[base0 + 1], 32'd1);
        checkOutput("t3_data1", log0Data[base0 + 1], 32'h00221820);

        $display("[TB] zero-length load");
        base0 = log0N;
        applyStimulus(1'b0, 0);
        checkOutput("zero_done_e1",  {31'd0, done0},  32'd0);
        checkOutput("zero_hold_e1",  {31'd0, hold0},  32'd1);
        checkOutput("zero_ready_e1", {31'd0, ready0}, 32'd0);
        @(negedge clk);
        checkOutput("zero_done_e2", {31'd0, done0}, 32'd1);
        checkOutput("zero_hold_e2", {31'd0, hold0}, 32'd0);
        @(negedge clk);
        checkOutput("zero_count", 32'(log0N - base0), 32'd0);

        $display("[TB] reset during load");
        base0 = log0N;
        applyStimulus(1'b0, 3);
        sendStream(8, 6, 1'b0);
        checkOutput("mid_ready", {31'd0, ready0}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_ready", {31'd0, ready0}, 32'd0);
        checkOutput("async_we",    {31'd0, we0},    32'd0);
        checkOutput("async_addr",  addr0,           32'd0);
        checkOutput("async_wdata", wdata0,          32'd0);
        checkOutput("async_hold",  {31'd0, hold0},  32'd1);
        checkOutput("async_done",  {31'd0, done0},  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_in    = 8'hE0 + 8'(k);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        @(negedge clk);
        checkOutput("t5_count",  32'(log0N - base0), 32'd1);
        checkOutput("t5_data0",  log0Data[base0],    32'h11223344);
        checkOutput("t5_hold",   {31'd0, hold0},     32'd1);
        checkOutput("t5_idle_ready", {31'd0, ready0}, 32'd0);
        applyStimulus(1'b0, 1);
        sendStream(20, 4, 1'b0);
        waitDone(1'b0);
        checkOutput("t5_count2", 32'(log0N - base0), 32'd2);
        checkOutput("t5_addr1",  log0Addr[base0 + 1], 32'd0);
        checkOutput("t5_data1",  log0Data[base0 + 1], 32'h12345678);

        $display("[TB] wrap from top address, start during load");
        checkOutput("u1_idle_hold", {31'd0, hold1}, 32'd1);
        base1 = log1N;
        applyStimulus(1'b1, 2);
        sendStream(24, 4, 1'b0);
        @(negedge clk);
        num_words = 32'd5;
        start1    = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        sendStream(28, 4, 1'b0);
        waitDone(1'b1);
        checkOutput("t6_count", 32'(log1N - base1), 32'd2);
        checkOutput("t6_addr0", log1Addr[base1],     32'd7);
        checkOutput("t6_data0", log1Data[base1],     32'h01020304);
        checkOutput("t6_addr1", log1Addr[base1 + 1], 32'd0);
        checkOutput("t6_data1", log1Data[base1 + 1], 32'hA0B0C0D0);
        checkOutput("t6_hold",  {31'd0, hold1},      32'd0);
        repeat (4) @(negedge clk);
        checkOutput("t6_count_after", 32'(log1N - base1), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
